// File: rtl/fetch_if.sv
// Bundle of signals between fetch_unit and its neighbours: next-PC logic,
// instruction memory, and the decode-side fetch queue.
interface fetch_if #(
  parameter int WIDTH_PC   = 32,
  parameter int WIDTH_INST = 32
);
  logic [WIDTH_PC-1:0]   npc;
  logic                  risk_Ctrl;
  logic [WIDTH_PC-1:0]   current_pc;
  logic [WIDTH_INST-1:0] inst;
  logic                  stop_IF;
  logic [WIDTH_PC-1:0]   imem_addr;
  logic [WIDTH_INST-1:0] imem_rdata;
  logic                  imem_rdy;
  logic                  id_valid;
  logic [WIDTH_PC-1:0]   id_pc;
  logic [WIDTH_INST-1:0] id_inst;
  logic                  id_ready;
  logic [15:0]           flush_cnt;

  // Decode handshake: an entry transfers on every rising edge where
  // id_valid && id_ready; id_valid never depends on id_ready, and id_pc/id_inst
  // are meaningful only while id_valid is high.
  modport slave (
    input  npc, risk_Ctrl, imem_rdata, imem_rdy, id_ready,
    output current_pc, inst, stop_IF, imem_addr, id_valid, id_pc, id_inst, flush_cnt
  );

  modport master (
    output npc, risk_Ctrl, imem_rdata, imem_rdy, id_ready,
    input  current_pc, inst, stop_IF, imem_addr, id_valid, id_pc, id_inst, flush_cnt
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC register and a DEPTH-entry {pc, inst}
// queue toward decode; redirects flush the queue and are counted.
module fetch_unit #(
  parameter int                WIDTH_PC   = 32,
  parameter int                WIDTH_INST = 32,
  parameter int                DEPTH      = 2,
  parameter logic [WIDTH_PC-1:0] RESET_PC = '0
) (
  input  logic   clk,
  input  logic   rst,
  fetch_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  logic [WIDTH_PC-1:0]   pc_q;
  logic [WIDTH_PC-1:0]   pc_mem   [DEPTH];
  logic [WIDTH_INST-1:0] inst_mem [DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [AW:0]           count_q;
  logic [15:0]           flush_cnt_q;

  logic full, empty, stop_if, fire, pop;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  // Deliberately independent of id_ready so decode never feeds next-PC logic.
  assign stop_if = (~bus.imem_rdy | full) & ~bus.risk_Ctrl;
  assign fire    = ~stop_if & ~bus.risk_Ctrl;
  assign pop     = ~empty & bus.id_ready & ~bus.risk_Ctrl;

  assign bus.current_pc = pc_q;
  assign bus.imem_addr  = pc_q;
  assign bus.inst       = bus.imem_rdata;
  assign bus.stop_IF    = stop_if;
  assign bus.id_valid   = ~empty;
  assign bus.id_pc      = pc_mem[rd_ptr_q];
  assign bus.id_inst    = inst_mem[rd_ptr_q];
  assign bus.flush_cnt  = flush_cnt_q;

  // Storage needs no reset: entries are only visible through valid pointers.
  always_ff @(posedge clk) begin
    if (fire) begin
      pc_mem[wr_ptr_q]   <= pc_q;
      inst_mem[wr_ptr_q] <= bus.imem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      flush_cnt_q <= '0;
    end else if (bus.risk_Ctrl) begin
      // Redirect wins over push, pop and memory wait.
      pc_q     <= bus.npc;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      if (flush_cnt_q != 16'hFFFF) flush_cnt_q <= flush_cnt_q + 16'd1;
    end else begin
      if (fire) begin
        pc_q     <= bus.npc;
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      unique case ({fire, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a queue-based reference model checked every
// cycle, plus literal expectations at the scenario milestones.
module tb_fetch_unit;
  localparam int DEPTH = 2;
  localparam logic [31:0] IMEM_KEY = 32'hC0DE_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fetch_if #(.WIDTH_PC(32), .WIDTH_INST(32)) bus ();

  fetch_unit #(
    .WIDTH_PC(32), .WIDTH_INST(32), .DEPTH(DEPTH), .RESET_PC(32'h0000_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock/reset block
  always #5 clk = ~clk;

  // Instruction memory: contents are a fixed function of the address.
  assign bus.imem_rdata = bus.imem_addr ^ IMEM_KEY;

  // Reference model state
  logic [63:0] exp_q[$];
  logic [31:0] m_pc;
  int          m_flush;
  bit          model_ok = 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  task automatic check_outputs();
    logic exp_stop;
    exp_stop = (!bus.imem_rdy || exp_q.size() == DEPTH) && !bus.risk_Ctrl;
    chk("current_pc", 64'(bus.current_pc), 64'(m_pc));
    chk("imem_addr",  64'(bus.imem_addr),  64'(m_pc));
    chk("inst",       64'(bus.inst),       64'(m_pc ^ IMEM_KEY));
    chk("stop_IF",    64'(bus.stop_IF),    64'(exp_stop));
    chk("id_valid",   64'(bus.id_valid),   64'(exp_q.size() != 0));
    chk("flush_cnt",  64'(bus.flush_cnt),  64'(m_flush));
    if (exp_q.size() != 0) chk("id_head", {bus.id_pc, bus.id_inst}, exp_q[0]);
  endtask

  task automatic model_edge(input logic r, input logic rdy, input logic rdy_id,
                            input logic risk, input logic [31:0] npc_v);
    bit full_now, do_pop, do_push;
    if (r) begin
      m_pc = 32'h0; exp_q.delete(); m_flush = 0; model_ok = 1'b1;
    end else if (risk) begin
      m_pc = npc_v; exp_q.delete();
      if (m_flush < 65535) m_flush++;
    end else if (model_ok) begin
      full_now = (exp_q.size() == DEPTH);
      do_pop   = (exp_q.size() != 0) && rdy_id;
      do_push  = rdy && !full_now;
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) begin
        exp_q.push_back({m_pc, m_pc ^ IMEM_KEY});
        m_pc = npc_v;
      end
    end
  endtask

  // Driver: one clock cycle with the given inputs. npc is current_pc+4 unless
  // redirecting, so any load during a stall would be visible.
  task automatic step(input logic r, input logic rdy, input logic rdy_id,
                      input logic risk, input logic [31:0] tgt);
    logic [31:0] npc_v;
    @(negedge clk);
    npc_v         = risk ? tgt : m_pc + 32'd4;
    rst           = r;
    bus.imem_rdy  = rdy;
    bus.id_ready  = rdy_id;
    bus.risk_Ctrl = risk;
    bus.npc       = npc_v;
    #2;
    if (model_ok) check_outputs();
    @(posedge clk);
    model_edge(r, rdy, rdy_id, risk, npc_v);
    #1;
  endtask

  task automatic run(input int n, input logic rdy, input logic rdy_id);
    for (int i = 0; i < n; i++) step(1'b0, rdy, rdy_id, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
  endtask

  initial begin
    bus.imem_rdy  = 1'b1;
    bus.id_ready  = 1'b1;
    bus.risk_Ctrl = 1'b0;
    bus.npc       = 32'h0;

    // Reset state
    do_reset();
    chk("rst_pc",       64'(bus.current_pc), 64'h0);
    chk("rst_id_valid", 64'(bus.id_valid),   64'h0);
    chk("rst_flush",    64'(bus.flush_cnt),  64'h0);

    // Free run: one fetch per cycle, decode one behind
    run(6, 1'b1, 1'b1);
    chk("free_pc",   64'(bus.current_pc), 64'h18);
    chk("free_idpc", 64'(bus.id_pc),      64'h14);

    // Backpressure: two pushes then hold at 8
    do_reset();
    run(5, 1'b1, 1'b0);
    chk("bp_pc_held", 64'(bus.current_pc), 64'h8);
    chk("bp_head",    64'(bus.id_pc),      64'h0);
    run(1, 1'b1, 1'b1);
    chk("bp_bubble_pc",   64'(bus.current_pc), 64'h8);
    chk("bp_bubble_head", 64'(bus.id_pc),      64'h4);
    run(3, 1'b1, 1'b1);
    chk("bp_resume_pc", 64'(bus.current_pc), 64'h14);

    // Memory wait at 0x10
    do_reset();
    run(4, 1'b1, 1'b1);
    run(3, 1'b0, 1'b1);
    chk("mw_pc_held", 64'(bus.current_pc), 64'h10);
    chk("mw_drained", 64'(bus.id_valid),   64'h0);
    run(1, 1'b1, 1'b1);
    chk("mw_resume_pc",  64'(bus.current_pc), 64'h14);
    chk("mw_resume_hd",  64'(bus.id_pc),      64'h10);

    // Redirect with full queue holding 0x20, 0x24
    do_reset();
    run(8, 1'b1, 1'b1);
    run(1, 1'b0, 1'b1);
    run(2, 1'b1, 1'b0);
    chk("rd_full_pc", 64'(bus.current_pc), 64'h28);
    chk("rd_full_hd", 64'(bus.id_pc),      64'h20);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h100);
    chk("rd_valid", 64'(bus.id_valid),   64'h0);
    chk("rd_pc",    64'(bus.current_pc), 64'h100);
    chk("rd_flush", 64'(bus.flush_cnt),  64'h1);
    run(1, 1'b1, 1'b1);
    chk("rd_target_hd", 64'(bus.id_pc), 64'h100);

    // Redirect during memory wait, then redirect colliding with reset
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h200);
    chk("rw_pc",    64'(bus.current_pc), 64'h200);
    chk("rw_valid", 64'(bus.id_valid),   64'h0);
    chk("rw_flush", 64'(bus.flush_cnt),  64'h2);
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h300);
    chk("rr_pc",    64'(bus.current_pc), 64'h0);
    chk("rr_flush", 64'(bus.flush_cnt),  64'h0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);

    // Saturation of the redirect counter
    for (int i = 0; i < 65537; i++)
      step(1'b0, i[0], i[1], 1'b1, 32'h1000 + 32'(i) * 32'd4);
    chk("sat_flush", 64'(bus.flush_cnt), 64'hFFFF);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h400);
    chk("sat_hold", 64'(bus.flush_cnt), 64'hFFFF);

    // Pointer wrap: repeated fill/drain, every head checked by the model
    for (int k = 0; k < 12; k++) begin
      run(3, 1'b1, 1'b0);
      run(3, 1'b0, 1'b1);
    end
    chk("wrap_pc",    64'(bus.current_pc), 64'h400 + 64'd96);
    chk("wrap_empty", 64'(bus.id_valid),   64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that owns the architectural PC register and a small fetch queue toward decode. Each cycle it presents `current_pc` and the combinationally read instruction to the next-PC logic, then loads the `npc` that logic returns. Fetched {pc, inst} pairs are buffered in a DEPTH-entry FIFO for the ID stage. The block generates `stop_IF` when fetch must hold and flushes wrong-path entries when `risk_Ctrl` signals a misprediction.

## Interface
- WIDTH_PC, 32, PC width (matches `WIDTH_PC`)
- WIDTH_INST, 32, instruction width (matches `WIDTH_INST`)
- DEPTH, 2, fetch-queue entries; power of two, ≥2
- RESET_PC, 32'h0000_0000, PC value after reset
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- npc  in  WIDTH_PC  next PC from next-PC logic (already accounts for stall and redirect)
- risk_Ctrl  in  1  misprediction/redirect this cycle; `npc` is the correct-path target
- current_pc  out  WIDTH_PC  PC register value; also drives instruction-memory address
- inst  out  WIDTH_INST  instruction at `current_pc` (pass-through of `imem_rdata`)
- stop_IF  out  1  fetch hold request to next-PC logic
- imem_addr  out  WIDTH_PC  = `current_pc`
- imem_rdata  in  WIDTH_INST  asynchronous-read instruction memory data for `imem_addr`
- imem_rdy  in  1  `imem_rdata` valid this cycle; 0 = memory wait
- id_valid  out  1  queue head valid
- id_pc  out  WIDTH_PC  queue head PC
- id_inst  out  WIDTH_INST  queue head instruction
- id_ready  in  1  decode consumes head this cycle when `id_valid`=1
- flush_cnt  out  16  saturating count of `risk_Ctrl` cycles since reset

## Operation
- Internal state: `pc_q`; FIFO storage DEPTH×(WIDTH_PC+WIDTH_INST); read and write pointers of log2(DEPTH) bits; `count` of log2(DEPTH)+1 bits; `flush_cnt`.
- `full` = (`count` == DEPTH); `empty` = (`count` == 0).
- `stop_IF` = (~`imem_rdy` | `full`) & ~`risk_Ctrl`. It does not depend on `id_ready`, so there is no combinational path from decode to next-PC logic.
- Fetch fire = ~`stop_IF` & ~`risk_Ctrl`. On fire: push {`pc_q`, `imem_rdata`} and set `pc_q` <= `npc`.
- Stall (`stop_IF`=1, no `risk_Ctrl`): `pc_q` holds, no push. Next-PC logic returns `npc` = `current_pc`; the block does not rely on this and simply does not load.
- Pop: when `id_valid` & `id_ready`, advance the read pointer.
- Redirect (`risk_Ctrl`=1) has priority over everything:
  - `pc_q` <= `npc`
  - FIFO cleared (pointers and `count` reset to 0); any same-cycle pop is ignored
  - no push; the instruction at `current_pc` is wrong-path and is discarded
  - `flush_cnt` += 1, saturating at 16'hFFFF
  - `pc_q` loads even if `imem_rdy`=0.
- Simultaneous push and pop: `count` unchanged, both pointers advance.
- When the queue is full and `id_ready`=1, pop happens but push is blocked that cycle because `stop_IF` was already asserted. Accept the bubble; full throughput needs DEPTH ≥ 2.
- Pointers wrap modulo DEPTH.
- `id_pc`/`id_inst` read the head entry combinationally. Their value is don't-care when `id_valid`=0.
- `id_valid` = ~`empty`.

## Timing
- Reset (rst=1 at a clock edge): `pc_q`=RESET_PC, `count`=0, pointers=0, `flush_cnt`=0.
  - Outputs after reset: `current_pc`=`imem_addr`=RESET_PC, `id_valid`=0, `stop_IF`=~`imem_rdy`.
  - Reset overrides `risk_Ctrl`, push and pop.
  - Reset mid-operation drops all queued entries.
- Fetch-to-decode latency: 1 cycle. An instruction pushed at edge N is visible on `id_*` after edge N (if the queue was empty).
- Redirect latency: target is on `current_pc` 1 cycle after the `risk_Ctrl` cycle. `id_valid`=0 that same cycle.
- `inst` and `stop_IF` are combinational within the cycle. `current_pc`, `id_*` and `flush_cnt` are registered or derived from registered state.

## Test plan
- Reset then free run: `imem_rdy`=1, `id_ready`=1, `npc`=`current_pc`+4. Expect `current_pc` 0,4,8,… and `id_pc` 0,4,8,… one cycle later, with `stop_IF`=0 throughout.
- Backpressure: `id_ready`=0 for 5 cycles. Expect 2 pushes (pc 0,4), then `stop_IF`=1 with `current_pc` held at 8. After `id_ready`=1: pops of 0 and 4, one bubble, then 8 is fetched.
- Memory wait: `imem_rdy`=0 for 3 cycles at pc 0x10. Expect `stop_IF`=1, `current_pc` stays 0x10, no push. Fetch resumes on the cycle `imem_rdy`=1.
- Redirect with full queue: queue holds 0x20,0x24; assert `risk_Ctrl` with `npc`=0x100 and `id_ready`=1. Next cycle: `id_valid`=0, `current_pc`=0x100, `flush_cnt`=1. Following cycle: `id_pc`=0x100.
- Redirect during memory wait: `imem_rdy`=0 and `risk_Ctrl`=1 with `npc`=0x200. Expect `stop_IF`=0 and `current_pc`=0x200 next cycle, no push. Also assert `risk_Ctrl` together with `rst`: expect `pc`=RESET_PC and `flush_cnt`=0.
- Saturation: force 65 537 `risk_Ctrl` cycles. Expect `flush_cnt`=16'hFFFF, and the pointer wrap pattern holds over ≥10 full/empty cycles with no lost or duplicated PCs.
